// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-stage register enables, flush strobes
// and a saturating stall-cycle counter. Outputs are combinational from state and hazards.
module pipe_stall_ctrl #(
  parameter int unsigned MULTI_LAT = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       dec_regA,
  input  logic [4:0]       dec_regB,
  input  logic             dec_uses_regB,
  input  logic             alu_mem_r_en,
  input  logic [4:0]       alu_regD,
  input  logic             alu_multi,
  input  logic             branch_taken,
  input  logic             block_pipe_instr_cache,
  input  logic             block_pipe_data_cache,
  output logic             EN_REG_FETCH,
  output logic             EN_REG_DECODE,
  output logic             EN_REG_ALU,
  output logic             EN_REG_MEM,
  output logic             flush_fetch,
  output logic             flush_decode,
  output logic             flush_alu,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {StRun, StDstall, StMulti} state_e;

  localparam logic [3:0] CntInit = 4'(MULTI_LAT - 2);

  state_e     state_q, state_d, ret_q, ret_d, eff_state;
  logic [3:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q;

  logic en_f, en_d, en_a, en_m, fl_f, fl_d, fl_a;
  logic load_use, stall_now;

  assign load_use = alu_mem_r_en && (alu_regD != 5'd0) &&
                    ((alu_regD == dec_regA) || (dec_uses_regB && (alu_regD == dec_regB)));

  always_comb begin
    en_f    = 1'b1;
    en_d    = 1'b1;
    en_a    = 1'b1;
    en_m    = 1'b1;
    fl_f    = 1'b0;
    fl_d    = 1'b0;
    fl_a    = 1'b0;
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    // DSTALL behaves as the state it interrupted; a held miss simply re-enters DSTALL.
    eff_state = (state_q == StDstall) ? ret_q : state_q;

    if (block_pipe_data_cache) begin
      en_f    = 1'b0;
      en_d    = 1'b0;
      en_a    = 1'b0;
      en_m    = 1'b0;
      state_d = StDstall;
      ret_d   = eff_state;
    end else if (eff_state == StMulti) begin
      en_f = 1'b0;
      en_d = 1'b0;
      en_a = 1'b0;
      fl_a = 1'b1;
      if (cnt_q == 4'd0) begin
        state_d = StRun;
      end else begin
        state_d = StMulti;
        cnt_d   = cnt_q - 4'd1;
      end
    end else begin
      state_d = StRun;
      if (branch_taken) begin
        fl_f = 1'b1;
        fl_d = 1'b1;
      end else if (alu_multi) begin
        en_f    = 1'b0;
        en_d    = 1'b0;
        en_a    = 1'b0;
        fl_a    = 1'b1;
        cnt_d   = CntInit;
        state_d = StMulti;
      end else if (load_use) begin
        en_f = 1'b0;
        fl_d = 1'b1;
      end else if (block_pipe_instr_cache) begin
        en_f = 1'b0;
        fl_f = 1'b1;
      end
    end
  end

  assign stall_now = !(en_f && en_d && en_a && en_m) || fl_f || fl_d || fl_a;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      ret_q   <= StRun;
      cnt_q   <= 4'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      if (stall_now && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    EN_REG_FETCH  = reset & en_f;
    EN_REG_DECODE = reset & en_d;
    EN_REG_ALU    = reset & en_a;
    EN_REG_MEM    = reset & en_m;
    flush_fetch   = reset & fl_f;
    flush_decode  = reset & fl_d;
    flush_alu     = reset & fl_a;
  end

  assign stall_cycles = stall_q;

endmodule
